// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - MD op classes, MD opcodes, issue FSM states and decode helpers
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MTHI    = 4'd5,
        MTLO    = 4'd6,
        MFHI    = 4'd7,
        MFLO    = 4'd8
    } md_op_e;

    localparam logic [2:0] MD_OPT_MULT  = 3'b000;
    localparam logic [2:0] MD_OPT_MULTU = 3'b001;
    localparam logic [2:0] MD_OPT_DIV   = 3'b010;
    localparam logic [2:0] MD_OPT_DIVU  = 3'b011;
    localparam logic [2:0] MD_OPT_MTHI  = 3'b100;
    localparam logic [2:0] MD_OPT_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Ops that hand work to MD; MFHI/MFLO only read HI/LO and never start it.
    function automatic logic is_write(input logic [3:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) ||
               (op == DIVU) || (op == MTHI)  || (op == MTLO);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == DIV) || (op == DIVU);
    endfunction

    function automatic logic [2:0] opt_of(input logic [3:0] op);
        logic [2:0] opt;
        case (op)
            MULTU:   opt = MD_OPT_MULTU;
            DIV:     opt = MD_OPT_DIV;
            DIVU:    opt = MD_OPT_DIVU;
            MTHI:    opt = MD_OPT_MTHI;
            MTLO:    opt = MD_OPT_MTLO;
            default: opt = MD_OPT_MULT;
        endcase
        return opt;
    endfunction

endpackage

// File: rtl/md_perf_cnt.sv
// rtl/md_perf_cnt.sv - free-running MD issue and stall counters, wrapping at 2^32
module md_perf_cnt (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_i,
    input  logic        stall_i,
    output logic [31:0] issue_cnt_o,
    output logic [31:0] stall_cnt_o
);

    logic [31:0] issue_q, issue_d;
    logic [31:0] stall_q, stall_d;

    always_comb begin
        issue_d = issue_q + {31'd0, issue_i};
        stall_d = stall_q + {31'd0, stall_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_q <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            issue_q <= issue_d;
            stall_q <= stall_d;
        end
    end

    assign issue_cnt_o = issue_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: rtl/md_issue_ctrl.sv
// rtl/md_issue_ctrl.sv - E-stage MD issue/stall controller; MD_PERF_CNT_EN adds issue/stall counters
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit DIV0_SKIP = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_valid,
    input  logic [3:0]        e_md_op,
    input  logic [DATA_W-1:0] e_rs,
    input  logic [DATA_W-1:0] e_rt,
    input  logic [3:0]        d_md_op,
    input  logic              flush,
    input  logic              md_busy,
    input  logic [DATA_W-1:0] md_hi,
    input  logic [DATA_W-1:0] md_lo,
    output logic              md_start,
    output logic [2:0]        md_opt,
    output logic [DATA_W-1:0] md_v1,
    output logic [DATA_W-1:0] md_v2,
    output logic [DATA_W-1:0] e_md_rdata,
    output logic              stall_md,
    output logic              md_pending
`ifdef MD_PERF_CNT_EN
    ,
    output logic [31:0]       md_issue_cnt,
    output logic [31:0]       md_stall_cnt
`endif
);

    md_state_e state_q, state_d;
    logic      start_q, start_d;
    logic      div_zero;

    assign div_zero   = DIV0_SKIP && is_div(e_md_op) && (e_rt == '0);
    assign md_start   = e_valid && is_write(e_md_op) && !flush && !div_zero;
    assign md_opt     = md_start ? opt_of(e_md_op) : MD_OPT_MULT;
    assign md_v1      = e_rs;
    assign md_v2      = e_rt;
    assign e_md_rdata = (e_md_op == MFHI) ? md_hi : md_lo;

    // start_q bridges the cycle after start, before MD has raised busy.
    assign md_pending = md_start || start_q || md_busy;
    assign stall_md   = (d_md_op != MD_NONE) && md_pending;

    always_comb begin
        state_d = state_q;
        start_d = md_start;
        case (state_q)
            IDLE:    if (md_start) state_d = RUN;
            RUN:     if (!md_busy && !start_q && !md_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
        end
    end

    a_no_back_to_back: assert property (@(posedge clk) disable iff (reset)
        !(md_start && (start_q || md_busy)));
    a_start_implies_run: assert property (@(posedge clk) disable iff (reset)
        !(state_q == IDLE && start_q));

`ifdef MD_PERF_CNT_EN
    md_perf_cnt u_perf (
        .clk         (clk),
        .reset       (reset),
        .issue_i     (md_start),
        .stall_i     (stall_md),
        .issue_cnt_o (md_issue_cnt),
        .stall_cnt_o (md_stall_cnt)
    );
`endif

endmodule
